// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter.
// Consumes one BCD digit per clock, most significant digit first, using
// acc = acc*10 + digit. A conversion takes N_DIGITS cycles after start.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; binary/err hold the last completed result
// CONV  | accumulating one digit per clock from the top of the shift reg
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   start   conversion request, sampled only while busy=0
//   bcd_in  packed BCD, digit 0 in [3:0]
//   busy    conversion in progress
//   done    one-cycle pulse, result valid
//   err     last converted input had a nibble > 9
//   binary  converted value, held between done pulses
module bcd2bin_seq #(
    parameter int N_DIGITS = 8,
    parameter int OUT_W    = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [OUT_W-1:0]      binary
);

    localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SR_W  = 4 * N_DIGITS;
    localparam int ACC_W = OUT_W + 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state, state_nxt;
    logic [SR_W-1:0]  sreg, sreg_nxt;
    logic [OUT_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             bad, bad_nxt;
    logic             done_nxt, err_nxt;
    logic [OUT_W-1:0] binary_nxt;

    logic [3:0]       d;
    logic [ACC_W-1:0] acc_wide;
    logic [ACC_W-1:0] step;
    logic             bad_step;

    // Multiply by ten as shift-and-add, carried 4 bits wider than the result.
    assign d        = sreg[SR_W-1 -: 4];
    assign acc_wide = {4'b0, acc};
    assign step     = (acc_wide << 3) + (acc_wide << 1) + ACC_W'(d);
    assign bad_step = bad | (d > 4'd9);

    assign busy = (state == CONV);

    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        bad_nxt    = bad;
        done_nxt   = 1'b0;
        err_nxt    = err;
        binary_nxt = binary;
        case (state)
            IDLE: begin
                if (start) begin
                    sreg_nxt  = bcd_in;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    bad_nxt   = 1'b0;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                acc_nxt  = step[OUT_W-1:0];
                sreg_nxt = sreg << 4;
                cnt_nxt  = cnt + CNT_W'(1);
                bad_nxt  = bad_step;
                if (cnt == LAST) begin
                    // Invalid input never exposes a partial value.
                    binary_nxt = bad_step ? '0 : step[OUT_W-1:0];
                    err_nxt    = bad_step;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            acc    <= '0;
            cnt    <= '0;
            bad    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            binary <= '0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            bad    <= bad_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
            binary <= binary_nxt;
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [26:0] binary;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    // Scoreboard entries are {err, binary}.
    logic [27:0] sb[$];

    bcd2bin_seq #(.N_DIGITS(8), .OUT_W(27)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .binary (binary)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] model(input logic [31:0] v);
        int unsigned val;
        logic        e;
        logic [3:0]  nib;
        val = 0;
        e   = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            nib = v[i*4 +: 4];
            if (nib > 4'd9) e = 1'b1;
            val = val * 10 + int'(nib);
        end
        if (e) val = 0;
        return {e, val[26:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample at the falling edge; done pops the scoreboard.
    task automatic tick();
        logic [27:0] e;
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_binary", 32'(binary), 32'(e[26:0]));
                chk("sb_err", 32'(err), 32'(e[27]));
            end
        end
    endtask

    task automatic start_conv(input logic [31:0] v);
        bcd_in = v;
        start  = 1'b1;
        sb.push_back(model(v));
        tick();
        start  = 1'b0;
    endtask

    // Full conversion with cycle-by-cycle busy/done timing checks.
    task automatic run_conv(input logic [31:0] v);
        start_conv(v);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) begin
                chk($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
                chk($sformatf("nodone_c%0d", i), 32'(done), 32'd0);
            end else begin
                chk("done_c8", 32'(done), 32'd1);
                chk("idle_c8", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        int d0;
        logic [31:0] rv;

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_binary", 32'(binary), 32'd0);

        start_conv(32'h1234_5678);
        chk("busy_c0", 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) chk($sformatf("busy12_c%0d", i), 32'(busy), 32'd1);
        end
        chk("done_12345678", 32'(done), 32'd1);
        chk("tp_12345678", 32'(binary), 32'h0BC614E);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);

        run_conv(32'h9999_9999);
        chk("tp_99999999", 32'(binary), 32'h5F5E0FF);
        chk("tp_99999999_err", 32'(err), 32'd0);

        run_conv(32'h0000_0000);
        chk("tp_zero", 32'(binary), 32'd0);

        run_conv(32'h0000_00A0);
        chk("tp_bad_bin", 32'(binary), 32'd0);
        chk("tp_bad_err", 32'(err), 32'd1);

        // Ignored start while busy, then back-to-back start on the done cycle.
        d0 = n_done;
        start_conv(32'h0000_0042);
        tick();
        tick();
        bcd_in = 32'h0000_0077;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("ignored_busy", 32'(busy), 32'd1);
        for (int i = 4; i <= 8; i++) tick();
        chk("b2b_done1", 32'(done), 32'd1);
        chk("b2b_bin42", 32'(binary), 32'd42);
        chk("b2b_single_done", 32'(n_done), 32'(d0 + 1));
        start_conv(32'h0000_0077);
        chk("b2b_accepted", 32'(busy), 32'd1);
        chk("b2b_hold_c0", 32'(binary), 32'd42);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) chk($sformatf("b2b_hold_c%0d", i), 32'(binary), 32'd42);
        end
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_bin77", 32'(binary), 32'd77);
        chk("b2b_done_count", 32'(n_done), 32'(d0 + 2));

        // Reset mid-conversion aborts without a done.
        start_conv(32'h1234_5678);
        for (int i = 1; i <= 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        d0 = n_done;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_binary", 32'(binary), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_no_done", 32'(n_done), 32'(d0));

        for (int k = 0; k < 6; k++) begin
            rv = '0;
            for (int j = 0; j < 8; j++) rv[j*4 +: 4] = 4'($urandom_range(0, 9));
            run_conv(rv);
        end
        run_conv(32'h1F00_0003);
        chk("bad_hi_err", 32'(err), 32'd1);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
